// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder (generators 7,5 octal) with
// valid/ready streaming, two-symbol zero tail and a frame length cap.
module conv_encoder #(
    parameter int MAX_LEN = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_last,
    output logic [1:0] enc_state,
    output logic       len_err
);

    localparam int CW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] TAIL1 = 2'd2;
    localparam logic [1:0] TAIL2 = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sym_q, sym_d;
    logic          vld_q, vld_d;
    logic          last_q, last_d;
    logic          lerr_q, lerr_d;
    logic          live_q;

    logic          slot_free;
    logic          in_phase;
    logic          tail_phase;
    logic          accept;
    logic          tail_go;
    logic          gen;
    logic          u;
    logic [CW-1:0] cnt_inc;
    logic          at_max;

    assign slot_free  = !vld_q || out_ready;
    assign in_phase   = (state_q == IDLE) || (state_q == DATA);
    assign tail_phase = (state_q == TAIL1) || (state_q == TAIL2);

    // live_q keeps the input closed for the first cycle after reset release
    assign in_ready = live_q && in_phase && slot_free;
    assign accept   = in_valid && in_ready;
    assign tail_go  = tail_phase && slot_free;
    assign gen      = accept || tail_go;
    assign u        = accept ? in_bit : 1'b0;

    assign cnt_inc = cnt_q + 1'b1;
    assign at_max  = (cnt_inc == CW'(MAX_LEN));

    always_comb begin
        sym_d  = sym_q;
        vld_d  = vld_q;
        last_d = last_q;
        sr_d   = sr_q;
        if (gen) begin
            sym_d  = {u ^ sr_q[1], u ^ sr_q[0] ^ sr_q[1]};
            sr_d   = {sr_q[0], u};
            vld_d  = 1'b1;
            last_d = (state_q == TAIL2);
        end else if (out_ready) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lerr_d  = 1'b0;
        unique case (state_q)
            IDLE, DATA: begin
                if (accept) begin
                    cnt_d   = cnt_inc;
                    lerr_d  = at_max && !in_last;
                    state_d = (in_last || at_max) ? TAIL1 : DATA;
                end
            end
            TAIL1: begin
                if (tail_go) state_d = TAIL2;
            end
            TAIL2: begin
                if (tail_go) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= 2'b00;
            cnt_q   <= '0;
            sym_q   <= 2'b00;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            lerr_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            lerr_q  <= lerr_d;
            live_q  <= 1'b1;
        end
    end

    assign out_valid = vld_q;
    assign out_sym   = sym_q;
    assign out_last  = last_q;
    assign enc_state = sr_q;
    assign len_err   = lerr_q;

endmodule
